mull_unit: RTL and testbench

//  Multi-cycle long-multiply execution unit (UMULL/SMULL/UMLAL/SMLAL). Drives the register

---
 rtl/arm_pkg.sv | 13 +
 rtl/mull_unit_step.sv | 21 ++
 rtl/mull_unit.sv | 149 ++++++++++++++
 tb/tb_mull_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the multicycle datapath: long-multiply FSM states and default width.
package arm_pkg;

  localparam int unsigned MULL_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StWb
  } mull_state_t;

endpackage

// File: rtl/mull_unit_step.sv
// One radix-2 shift-add iteration: conditionally add the multiplicand into the high half,
// then shift the {carry, hi, lo} accumulator right by one.
module mull_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(WIDTH + 1){1'b0}});
    hi_next = sum[WIDTH:1];
    lo_next = {sum[0], lo[WIDTH-1:1]};
  end

endmodule

// File: rtl/mull_unit.sv
// Multi-cycle long multiply (UMULL/SMULL/UMLAL/SMLAL) that writes RdLo/RdHi to the register
// file in a single dual-port writeback cycle.
module mull_unit
  import arm_pkg::*;
#(
  parameter int unsigned WIDTH = MULL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             Signed,
  input  logic             Acc,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [3:0]       rdlo,
  input  logic [3:0]       rdhi,
  output logic             busy,
  output logic             done,
  output logic             we3,
  output logic [3:0]       a3,
  output logic [WIDTH-1:0] wd3,
  output logic [3:0]       a4,
  output logic [WIDTH-1:0] wd4,
  output logic             Long
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;

  mull_state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [PW-1:0]    acc_q;
  logic             neg_q;
  logic             acc_en_q;
  logic [3:0]       rdlo_q;
  logic [3:0]       rdhi_q;
  logic [3:0]       a3_q;
  logic [3:0]       a4_q;
  logic [WIDTH-1:0] wd3_q;
  logic [WIDTH-1:0] wd4_q;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;
  logic [PW-1:0]    prod_mag;
  logic [PW-1:0]    prod_sgn;
  logic [PW-1:0]    result;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  always_comb begin
    mag_a = (Signed && srca[WIDTH-1]) ? (~srca + WIDTH'(1)) : srca;
    mag_b = (Signed && srcb[WIDTH-1]) ? (~srcb + WIDTH'(1)) : srcb;
  end

  mull_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .hi     (hi_q),
    .lo     (lo_q),
    .mcand  (mcand_q),
    .hi_next(hi_next),
    .lo_next(lo_next)
  );

  // Sign fix-up and accumulate; carry out of the top bit is dropped.
  always_comb begin
    prod_mag = {hi_q, lo_q};
    prod_sgn = neg_q ? (~prod_mag + PW'(1)) : prod_mag;
    result   = prod_sgn + (acc_en_q ? acc_q : {PW{1'b0}});
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (cnt_q == CW'(WIDTH - 1)) state_d = StFix;
      StFix:   state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      acc_en_q <= 1'b0;
      rdlo_q   <= '0;
      rdhi_q   <= '0;
      a3_q     <= '0;
      a4_q     <= '0;
      wd3_q    <= '0;
      wd4_q    <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cnt_q    <= '0;
            mcand_q  <= mag_a;
            hi_q     <= '0;
            lo_q     <= mag_b;
            acc_q    <= {acc_hi, acc_lo};
            neg_q    <= Signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            acc_en_q <= Acc;
            rdlo_q   <= rdlo;
            rdhi_q   <= rdhi;
          end
        end
        StRun: begin
          hi_q  <= hi_next;
          lo_q  <= lo_next;
          cnt_q <= cnt_q + CW'(1);
        end
        StFix: begin
          wd3_q <= result[WIDTH-1:0];
          wd4_q <= result[PW-1:WIDTH];
          a3_q  <= rdlo_q;
          a4_q  <= rdhi_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != StIdle);
    we3  = (state_q == StWb);
    done = we3;
    Long = we3;
    a3   = a3_q;
    a4   = a4_q;
    wd3  = wd3_q;
    wd4  = wd4_q;
  end

endmodule

// File: tb/tb_mull_unit.sv
// Self-checking bench for mull_unit: vector table plus scoreboard of expected writebacks.
module tb_mull_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        Signed;
  logic        Acc;
  logic [31:0] srca, srcb, acc_lo, acc_hi;
  logic [3:0]  rdlo, rdhi;
  logic        busy, done, we3, Long;
  logic [3:0]  a3, a4;
  logic [31:0] wd3, wd4;

  mull_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .Signed(Signed),
    .Acc   (Acc),
    .srca  (srca),
    .srcb  (srcb),
    .acc_lo(acc_lo),
    .acc_hi(acc_hi),
    .rdlo  (rdlo),
    .rdhi  (rdhi),
    .busy  (busy),
    .done  (done),
    .we3   (we3),
    .a3    (a3),
    .wd3   (wd3),
    .a4    (a4),
    .wd4   (wd4),
    .Long  (Long)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a, b, ah, al;
    logic        sg, acc;
    logic [3:0]  rl, rh;
    logic [31:0] lo, hi;
  } vec_t;

  typedef struct {
    logic [31:0] lo, hi;
    logic [3:0]  rl, rh;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, b, ah, al, input logic sg, acc,
                              input logic [3:0] rl, rh, input logic [31:0] lo, hi);
    vec_t v;
    v.a = a; v.b = b; v.ah = ah; v.al = al; v.sg = sg; v.acc = acc;
    v.rl = rl; v.rh = rh; v.lo = lo; v.hi = hi;
    return v;
  endfunction

  // Reference: sign-extend to 64 bits and multiply; low 64 bits are the exact result.
  function automatic logic [63:0] model(input vec_t v);
    logic [63:0] ea, eb, p;
    ea = {{32{v.sg & v.a[31]}}, v.a};
    eb = {{32{v.sg & v.b[31]}}, v.b};
    p  = ea * eb;
    if (v.acc) p = p + {v.ah, v.al};
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    srca = v.a; srcb = v.b; acc_hi = v.ah; acc_lo = v.al;
    Signed = v.sg; Acc = v.acc; rdlo = v.rl; rdhi = v.rh;
    start = 1'b1;
  endtask

  task automatic scramble();
    srca = $urandom; srcb = $urandom; acc_hi = $urandom; acc_lo = $urandom;
    Signed = 1'($urandom); Acc = 1'($urandom);
    rdlo = 4'($urandom); rdhi = 4'($urandom);
  endtask

  task automatic push(input vec_t v, input int at);
    exp_t e;
    e.lo = v.lo; e.hi = v.hi; e.rl = v.rl; e.rh = v.rh; e.at = at;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) step();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending writebacks expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_op(input vec_t v);
    step();
    apply(v);
    push(v, cyc + 34);
    step();
    start = 1'b0;
    scramble();
    @(negedge clk);
    chk("busy_run", 64'(busy), 64'(1));
    wait_drain();
  endtask

  // Writeback monitor: every we3 pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (we3) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got we3=1 at cycle %0d expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_cycle", 64'(cyc), 64'(mon_e.at));
        chk("a3", 64'(a3), 64'(mon_e.rl));
        chk("wd3", 64'(wd3), 64'(mon_e.lo));
        chk("a4", 64'(a4), 64'(mon_e.rh));
        chk("wd4", 64'(wd4), 64'(mon_e.hi));
        chk("long", 64'(Long), 64'(1));
        chk("done", 64'(done), 64'(1));
        chk("busy_wb", 64'(busy), 64'(1));
      end
    end else begin
      if (done !== 1'b0 || Long !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL strobe_idle: got done=%b Long=%b expected 0", done, Long);
      end
    end
  end

  vec_t tbl[9];
  vec_t v;
  vec_t op2;
  int   c0;

  initial begin
    tbl[0] = mk(32'd3, 32'd5, 32'h0, 32'h0, 1'b0, 1'b0, 4'd2, 4'd3,
                32'h0000000F, 32'h00000000);
    tbl[1] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 1'b0, 4'd4, 4'd5,
                32'h00000001, 32'hFFFFFFFE);
    tbl[2] = mk(32'hFFFFFFFF, 32'd2, 32'h0, 32'h0, 1'b1, 1'b0, 4'd0, 4'd1,
                32'hFFFFFFFE, 32'hFFFFFFFF);
    tbl[3] = mk(32'h80000000, 32'h80000000, 32'h0, 32'h0, 1'b1, 1'b0, 4'd6, 4'd7,
                32'h00000000, 32'h40000000);
    tbl[4] = mk(32'hFFFFFFFF, 32'd1, 32'h0, 32'h1, 1'b1, 1'b1, 4'd8, 4'd9,
                32'h00000000, 32'h00000000);
    tbl[5] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 4'd10,
                4'd11, 32'h00000000, 32'hFFFFFFFE);
    tbl[6] = mk(32'h80000000, 32'h7FFFFFFF, 32'h0, 32'h0, 1'b1, 1'b0, 4'd15, 4'd15,
                32'h80000000, 32'hC0000000);
    tbl[7] = mk(32'h12345678, 32'h0, 32'h5, 32'h6, 1'b0, 1'b1, 4'd12, 4'd13,
                32'h00000006, 32'h00000005);
    tbl[8] = mk(32'd7, 32'hFFFFFFFD, 32'h0, 32'h0, 1'b1, 1'b0, 4'd1, 4'd14,
                32'hFFFFFFEB, 32'hFFFFFFFF);

    reset = 1'b1;
    start = 1'b0;
    scramble();
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_we3", 64'(we3), 64'(0));
    chk("rst_a3a4", 64'({a3, a4}), 64'(0));
    chk("rst_wd3", 64'(wd3), 64'(0));
    chk("rst_wd4", 64'(wd4), 64'(0));

    foreach (tbl[i]) do_op(tbl[i]);

    for (int i = 0; i < 4; i++) begin
      v = mk($urandom, $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom),
             4'($urandom), 4'($urandom), 32'h0, 32'h0);
      {v.hi, v.lo} = model(v);
      do_op(v);
    end

    // Starts during busy and in the writeback cycle are ignored; next accept follows WB.
    op2 = mk(32'd100, 32'd200, 32'h0, 32'h0, 1'b0, 1'b0, 4'd7, 4'd8, 32'h0, 32'h0);
    step();
    c0 = cyc;
    apply(tbl[8]);
    push(tbl[8], c0 + 34);
    step();
    start = 1'b0;
    while (cyc < c0 + 5) step();
    apply(op2);
    step();
    start = 1'b0;
    while (cyc < c0 + 34) step();
    apply(op2);
    step();
    apply(tbl[1]);
    push(tbl[1], c0 + 69);
    @(negedge clk);
    chk("busy_after_wb", 64'(busy), 64'(0));
    step();
    start = 1'b0;
    wait_drain();

    // Reset mid-operation aborts without a write.
    step();
    c0 = cyc;
    apply(tbl[2]);
    step();
    start = 1'b0;
    while (cyc < c0 + 20) step();
    @(negedge clk);
    chk("busy_before_rst", 64'(busy), 64'(1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("busy_after_rst", 64'(busy), 64'(0));
    repeat (40) step();
    do_op(tbl[3]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
